keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scanner_col_sync.sv | 36 +++
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 keypad scanner.
//   state_e       : scanner FSM states
//   key_code_t    : accepted key coordinate {row[1:0], col[1:0]}
//   KEY_ZERO_CODE : coordinate of the '0' key, used as the reset key code
//   highest_col() : priority pick of the highest set column bit
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_ZERO_CODE = 4'd13;

  // When several columns read high in one row, the highest column wins.
  function automatic logic [1:0] highest_col(input logic [3:0] c);
    if (c[3])      return 2'd3;
    else if (c[2]) return 2'd2;
    else if (c[1]) return 2'd1;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// -----------------------------------------------------------------------------
// col_sync
// Two-flop synchronizer for the asynchronous keypad column sense lines.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (both stages clear to 0)
//   col_i  : raw column inputs
//   col_o  : synchronized columns, two cycles of latency
// -----------------------------------------------------------------------------
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] col_i,
  output logic [WIDTH-1:0] col_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so both stages sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  assign col_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 keypad one row at a time, debounces press and release, and
// hands accepted keys to a consumer through a valid/ready handshake.
// Parameters:
//   SCAN_DIV        : clock cycles each row is driven before advancing
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a press or release
// Ports:
//   clk       : clock
//   reset     : asynchronous active-low reset
//   col       : raw column sense, active-high
//   row       : one-hot row drive, active-high
//   row_idx   : binary index of the driven row
//   key_code  : accepted key {row, col}
//   key_valid : key_code holds an unconsumed key
//   key_ready : consumer takes key_code this cycle
//   held      : a debounced key is currently down
//   overrun   : (only with KEYPAD_SCANNER_OVERRUN_EN) sticky flag, set when a
//               new key is dropped because the previous one was not consumed
// Configuration macro: KEYPAD_SCANNER_OVERRUN_EN
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [1:0] row_idx,
  output key_code_t key_code,
  output logic      key_valid,
  input  logic      key_ready,
  output logic      held
`ifdef KEYPAD_SCANNER_OVERRUN_EN
  ,
  output logic      overrun
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       row_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       col_idx_q;
  logic [DIV_W-1:0] div_q;
  logic [DB_W-1:0]  db_q;
  key_code_t        key_code_q;
  logic             key_valid_q;
  logic             held_q;
  logic [3:0]       col_s;

  col_sync #(.WIDTH(4)) u_col_sync (
    .clk   (clk),
    .rst_n (reset),
    .col_i (col),
    .col_o (col_s)
  );

  logic col_hit;
  logic dwell_last;
  logic key_evt;
  logic key_load;

  assign col_hit    = col_s[col_idx_q];
  assign dwell_last = (div_q == DIV_LAST);
  // A key is accepted on the last of DEBOUNCE_CYCLES consecutive highs.
  assign key_evt    = (state_q == DEBOUNCE) && col_hit && (db_q == DB_LAST);
  // An unconsumed key blocks a new one unless it is being taken this cycle.
  assign key_load   = key_evt && (!key_valid_q || key_ready);

  // NOTE: every register, including the key code, sits on the asynchronous
  // reset so a reset mid-debounce or mid-press leaves no half-built key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      row_q       <= 4'b0001;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      div_q       <= '0;
      db_q        <= '0;
      key_code_q  <= KEY_ZERO_CODE;
      key_valid_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      unique case (state_q)
        SCAN: begin
          if (dwell_last) begin
            if (|col_s) begin
              // Freeze the row and watch only the winning column.
              col_idx_q <= highest_col(col_s);
              db_q      <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              row_q     <= {row_q[2:0], row_q[3]};
              row_idx_q <= row_idx_q + 2'd1;
              div_q     <= '0;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        DEBOUNCE: begin
          if (col_hit) begin
            if (db_q == DB_LAST) begin
              db_q    <= '0;
              held_q  <= 1'b1;
              state_q <= PRESSED;
            end else begin
              db_q <= db_q + DB_W'(1);
            end
          end else begin
            // Bounce: give up on this key and move on to the next row.
            db_q      <= '0;
            state_q   <= SCAN;
            row_q     <= {row_q[2:0], row_q[3]};
            row_idx_q <= row_idx_q + 2'd1;
            div_q     <= '0;
          end
        end

        PRESSED: begin
          if (!col_hit) begin
            db_q    <= '0;
            state_q <= RELEASE;
          end
        end

        RELEASE: begin
          if (col_hit) begin
            // Release bounce: the key is still down, no new key event.
            db_q    <= '0;
            state_q <= PRESSED;
          end else if (db_q == DB_LAST) begin
            db_q      <= '0;
            held_q    <= 1'b0;
            state_q   <= SCAN;
            row_q     <= {row_q[2:0], row_q[3]};
            row_idx_q <= row_idx_q + 2'd1;
            div_q     <= '0;
          end else begin
            db_q <= db_q + DB_W'(1);
          end
        end

        default: state_q <= SCAN;
      endcase

      if (key_load) begin
        key_code_q  <= {row_idx_q, col_idx_q};
        key_valid_q <= 1'b1;
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_SCANNER_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (key_evt && !key_load) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

  assign row       = row_q;
  assign row_idx   = row_idx_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign held      = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// Column stimulus comes either from a keypad model (one key wired to one row,
// sensed only while that row is driven) or from direct per-cycle drive for
// bounce patterns. Expected latencies are hand-derived: with a key seen from
// the cycle its row is first driven, key_valid rises 12 edges later
// (3 dwell edges + sample edge + 8 debounce edges); a clean release clears
// held 11 edges after the column drops (2 sync + 1 detect + 8 release edges).
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 8;
  localparam int LIMIT    = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [1:0] row_idx;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       held;
`ifdef KEYPAD_SCANNER_OVERRUN_EN
  logic       overrun;
`endif

  // Keypad model plus direct column drive.
  logic       kp_en = 1'b0;
  logic [3:0] kp_row = 4'b0001;
  logic [3:0] kp_mask = 4'b0000;
  logic [3:0] direct_col = 4'b0000;

  assign col = direct_col | ((kp_en && row == kp_row) ? kp_mask : 4'b0000);

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .row_idx   (row_idx),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .held      (held)
`ifdef KEYPAD_SCANNER_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic wait_held(input logic v, output int n);
    n = 0;
    while (held !== v && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic wait_row(input logic [3:0] r, output int n);
    n = 0;
    while (row !== r && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic consume();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;
    logic saw_valid;
    logic held_low;

    // ---------------- reset ----------------
    #2 reset = 1'b0;
    steps(2);
    check("rst_row", row, 4'b0001);
    check("rst_row_idx", row_idx, 2'd0);
    check("rst_key_code", key_code, 4'd13);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_held", held, 1'b0);
`ifdef KEYPAD_SCANNER_OVERRUN_EN
    check("rst_overrun", overrun, 1'b0);
`endif
    reset = 1'b1;

    // ---------------- idle scan ----------------
    for (int k = 1; k <= 16; k++) begin
      step();
      e = (k / SCAN_DIV) % 4;
      check("idle_row_idx", row_idx, e);
      check("idle_row", row, 32'(1) << e);
      check("idle_valid", key_valid, 1'b0);
    end
    check("idle_key_code", key_code, 4'd13);

    // ---------------- press in row 1, col 2 ----------------
    kp_row = 4'b0010; kp_mask = 4'b0100; kp_en = 1'b1;
    wait_row(4'b0010, n);
    check("p1_row_wait", n, 4);
    wait_valid(n);
    check("p1_latency", n, 12);
    check("p1_key_code", key_code, 4'b0110);
    check("p1_held", held, 1'b1);
    check("p1_row_frozen", row, 4'b0010);
    consume();
    check("p1_consumed", key_valid, 1'b0);
    check("p1_code_kept", key_code, 4'b0110);
    kp_en = 1'b0;
    wait_held(1'b0, n);
    check("p1_release_latency", n, 11);
    check("p1_next_row", row, 4'b0100);

    // ---------------- press bounce 1,1,0 in row 2 ----------------
    direct_col = 4'b0100;
    steps(4);
    direct_col = 4'b0000;
    steps(2);
    check("bnc_row_frozen", row_idx, 2'd2);
    check("bnc_valid_mid", key_valid, 1'b0);
    step();
    check("bnc_next_row", row_idx, 2'd3);
    check("bnc_valid", key_valid, 1'b0);
    check("bnc_held", held, 1'b0);

    // ---------------- release bounce 0,0,1 in row 3, col 0 ----------------
    direct_col = 4'b0001;
    wait_valid(n);
    check("rb_latency", n, 12);
    check("rb_key_code", key_code, 4'b1100);
    consume();
    check("rb_consumed", key_valid, 1'b0);
    direct_col = 4'b0000;
    steps(2);
    direct_col = 4'b0001;
    saw_valid = 1'b0;
    held_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      saw_valid |= key_valid;
      held_low  |= ~held;
    end
    check("rb_no_second_valid", saw_valid, 1'b0);
    check("rb_held_stays", held_low, 1'b0);
    check("rb_row_frozen", row_idx, 2'd3);
    direct_col = 4'b0000;
    wait_held(1'b0, n);
    check("rb_clean_release", n, 11);
    check("rb_next_row", row_idx, 2'd0);

    // ---------------- overrun: two presses, key_ready low ----------------
    kp_row = 4'b0001; kp_mask = 4'b1000; kp_en = 1'b1;
    wait_valid(n);
    check("ov1_latency", n, 12);
    check("ov1_key_code", key_code, 4'b0011);
`ifdef KEYPAD_SCANNER_OVERRUN_EN
    check("ov1_overrun", overrun, 1'b0);
`endif
    kp_en = 1'b0;
    wait_held(1'b0, n);
    check("ov1_release", n, 11);
    kp_row = 4'b0100; kp_mask = 4'b0001; kp_en = 1'b1;
    wait_held(1'b1, n);
    check("ov2_press_in_time", n < LIMIT, 1'b1);
    check("ov2_valid", key_valid, 1'b1);
    check("ov2_code_kept", key_code, 4'b0011);
`ifdef KEYPAD_SCANNER_OVERRUN_EN
    check("ov2_overrun", overrun, 1'b1);
`endif
    kp_en = 1'b0;
    wait_held(1'b0, n);
    check("ov2_release", n, 11);
    check("ov2_next_row", row_idx, 2'd3);

    // ---------------- accept and consume in the same cycle ----------------
    kp_row = 4'b0010; kp_mask = 4'b0001; kp_en = 1'b1;
    wait_row(4'b0010, n);
    check("sim_row_wait", n, 8);
    steps(11);
    check("sim_pre_held", held, 1'b0);
    check("sim_pre_code", key_code, 4'b0011);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("sim_valid", key_valid, 1'b1);
    check("sim_key_code", key_code, 4'b0100);
    check("sim_held", held, 1'b1);
`ifdef KEYPAD_SCANNER_OVERRUN_EN
    check("sim_overrun_sticky", overrun, 1'b1);
`endif
    consume();
    check("sim_consumed", key_valid, 1'b0);
    kp_en = 1'b0;
    wait_held(1'b0, n);
    check("sim_release", n, 11);

    // ---------------- highest column wins in row 3 ----------------
    kp_row = 4'b1000; kp_mask = 4'b1010; kp_en = 1'b1;
    wait_valid(n);
    check("hi_in_time", n < LIMIT, 1'b1);
    check("hi_key_code", key_code, 4'b1111);
    consume();
    kp_en = 1'b0;
    wait_held(1'b0, n);
    check("hi_release", n, 11);
    check("hi_next_row", row_idx, 2'd0);

    // ---------------- reset during debounce ----------------
    kp_row = 4'b0010; kp_mask = 4'b0001; kp_en = 1'b1;
    wait_row(4'b0010, n);
    check("rd_row_wait", n, 4);
    steps(6);
    reset = 1'b0;
    #2;
    check("rd_row", row, 4'b0001);
    check("rd_row_idx", row_idx, 2'd0);
    check("rd_valid", key_valid, 1'b0);
    check("rd_held", held, 1'b0);
    check("rd_key_code", key_code, 4'd13);
`ifdef KEYPAD_SCANNER_OVERRUN_EN
    check("rd_overrun", overrun, 1'b0);
`endif
    kp_en = 1'b0;
    reset = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      saw_valid |= key_valid;
    end
    check("rd_restart_row0", row_idx, 2'd0);
    step();
    saw_valid |= key_valid;
    check("rd_restart_row1", row_idx, 2'd1);
    check("rd_no_valid", saw_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
